// File: rtl/pingpong_buf_ctrl_pkg.sv
// pingpong_buf_ctrl_pkg: shared widths and FSM encodings for the ping-pong buffer controller
package pingpong_buf_ctrl_pkg;
    localparam int DATA_W = 18;
    typedef enum logic {W_FILL = 1'b0, W_WAIT = 1'b1} wstate_e;
    typedef enum logic {R_IDLE = 1'b0, R_DRAIN = 1'b1} rstate_e;
endpackage

// File: rtl/pingpong_buf_ctrl_skid.sv
// out_skid_buf: 2-entry FIFO of {last, data} that absorbs the RAM read latency
module out_skid_buf
    import pingpong_buf_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [DATA_W:0] push_data,
    input  logic            pop,
    output logic [1:0]      count,
    output logic [DATA_W:0] head
);
    logic [DATA_W:0] mem_q [2];
    logic [DATA_W:0] mem_d [2];
    logic            head_q, head_d;
    logic [1:0]      cnt_q, cnt_d;

    // push never meets a full buffer, so the tail slot is head ^ cnt[0]
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[head_q ^ cnt_q[0]] = push_data;
        head_d = head_q ^ pop;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            head_q <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            head_q <= head_d;
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign head = mem_q[head_q];
endmodule

// File: rtl/pingpong_buf_ctrl.sv
// pingpong_buf_ctrl: fills one RAM bank from an input stream while draining the other to an output stream
module pingpong_buf_ctrl
    import pingpong_buf_ctrl_pkg::*;
#(
    parameter int addr_size = 10
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_last,
    output logic                 ram_WE,
    output logic                 ram_switch,
    output logic [addr_size-1:0] ram_writeAddr,
    output logic [DATA_W-1:0]    ram_writeData,
    output logic [addr_size-1:0] ram_readAddr,
    input  logic [DATA_W-1:0]    ram_readData
);
    wstate_e              wstate_q, wstate_d;
    rstate_e              rstate_q, rstate_d;
    logic [addr_size-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic                 sw_q, sw_d, inflight_q, inflight_d, inflast_q, inflast_d;
    logic                 accept, pop, swap, issue;
    logic [1:0]           skid_count;
    logic [DATA_W:0]      skid_head;
    logic [2:0]           occ;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wstate_q <= W_FILL;
            rstate_q <= R_IDLE;
            wcnt_q <= '0;
            rcnt_q <= '0;
            sw_q <= 1'b0;
            inflight_q <= 1'b0;
            inflast_q <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
            sw_q <= sw_d;
            inflight_q <= inflight_d;
            inflast_q <= inflast_d;
        end
    end

    // a read may issue only if the skid can still hold its data after this edge's pop
    always_comb begin
        accept = in_valid & in_ready;
        pop = out_valid & out_ready;
        swap = (wstate_q == W_WAIT) && (rstate_q == R_IDLE);
        occ = {1'b0, skid_count} + {2'b0, inflight_q} - {2'b0, pop};
        issue = (rstate_q == R_DRAIN) && (occ <= 3'd1);
        wstate_d = swap ? W_FILL : (accept && &wcnt_q) ? W_WAIT : wstate_q;
        rstate_d = swap ? R_DRAIN : (issue && &rcnt_q) ? R_IDLE : rstate_q;
    end

    always_comb begin
        wcnt_d = accept ? wcnt_q + 1'b1 : wcnt_q;
        rcnt_d = swap ? '0 : issue ? rcnt_q + 1'b1 : rcnt_q;
        sw_d = sw_q ^ swap;
        inflight_d = issue;
        inflast_d = issue & (&rcnt_q);
    end

    always_comb begin
        in_ready = (wstate_q == W_FILL) && !RST;
        ram_WE = accept;
        ram_writeAddr = wcnt_q;
        ram_writeData = in_data;
        ram_readAddr = rcnt_q;
        ram_switch = sw_q;
        out_valid = skid_count != 2'd0;
        out_data = skid_head[DATA_W-1:0];
        out_last = skid_head[DATA_W];
    end

    out_skid_buf u_skid (
        .clk      (CLK),
        .rst      (RST),
        .push     (inflight_q),
        .push_data({inflast_q, ram_readData}),
        .pop      (pop),
        .count    (skid_count),
        .head     (skid_head)
    );
endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// tb_pingpong_buf_ctrl: scoreboard bench with a two-bank registered-read RAM model
module tb_pingpong_buf_ctrl;
    localparam int AW = 10;
    localparam int N = 1 << AW;

    logic          CLK = 1'b0, RST = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic          in_ready, out_valid, out_last, ram_WE, ram_switch;
    logic [17:0]   in_data = '0, ram_readData = '0;
    logic [17:0]   out_data, ram_writeData;
    logic [AW-1:0] ram_writeAddr, ram_readAddr;
    logic [17:0]   bank0 [N];
    logic [17:0]   bank1 [N];
    logic [18:0]   sb [$];
    logic [18:0]   e;
    logic          hold_v = 1'b0;
    logic [17:0]   hold_d = '0;
    int            checks = 0, failures = 0, in_cnt = 0, or_mode = 0, st = 0, gap = 0;

    always #5 CLK = ~CLK;

    pingpong_buf_ctrl #(.addr_size(AW)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .ram_WE(ram_WE), .ram_switch(ram_switch), .ram_writeAddr(ram_writeAddr),
        .ram_writeData(ram_writeData), .ram_readAddr(ram_readAddr), .ram_readData(ram_readData)
    );

    always @(posedge CLK) begin
        if (ram_WE && ram_switch) bank1[ram_writeAddr] <= ram_writeData;
        if (ram_WE && !ram_switch) bank0[ram_writeAddr] <= ram_writeData;
        ram_readData <= ram_switch ? bank0[ram_readAddr] : bank1[ram_readAddr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        #1;
        out_ready = (or_mode == 1) ? ~out_ready : (or_mode == 0);
    end

    initial forever begin
        @(negedge CLK);
        if (RST) begin
            sb.delete();
            in_cnt = 0;
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", {31'b0, out_valid}, 1);
                check("hold_data", {14'b0, out_data}, {14'b0, hold_d});
            end
            if (in_valid && in_ready) begin
                sb.push_back({(in_cnt % N) == N - 1, in_data});
                in_cnt++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("sb_underflow", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("out_data", {14'b0, out_data}, {14'b0, e[17:0]});
                    check("out_last", {31'b0, out_last}, {31'b0, e[18]});
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
        end
    end

    task automatic do_reset();
        RST = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic send_block(input int base, input int n, output int stall0);
        logic ok;
        stall0 = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data = 18'(base + i);
            for (int t = 0; ; t++) begin
                @(negedge CLK);
                ok = in_ready;
                if (!ok && i == 0) stall0++;
                @(posedge CLK);
                #1;
                if (ok) break;
                if (t > 6000) begin
                    check("in_timeout", 1, 0);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 6000) begin
            @(negedge CLK);
            t++;
        end
        check(tag, sb.size(), 0);
        @(posedge CLK);
        #1;
    endtask

    task automatic first_valid_gap(output int g);
        g = 0;
        forever begin
            @(negedge CLK);
            if (out_valid || g > 20) break;
            g++;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int p1, p2, t;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_in_ready", {31'b0, in_ready}, 0);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_last", {31'b0, out_last}, 0);
        check("rst_out_data", {14'b0, out_data}, 0);
        check("rst_switch", {31'b0, ram_switch}, 0);
        check("rst_we", {31'b0, ram_WE}, 0);
        check("rst_waddr", {22'b0, ram_writeAddr}, 0);
        check("rst_raddr", {22'b0, ram_readAddr}, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_in_ready", {31'b0, in_ready}, 1);
        @(posedge CLK);
        #1;

        send_block(0, N, st);
        check("single_sw_pre", {31'b0, ram_switch}, 0);
        first_valid_gap(gap);
        check("first_valid_gap", gap, 3);
        check("single_sw_post", {31'b0, ram_switch}, 1);
        wait_drain("single_drain");

        do_reset();
        send_block(0, N, st);
        check("b2b_sw_a", {31'b0, ram_switch}, 0);
        send_block(5000, N, st);
        check("b2b_gap", st, 1);
        check("b2b_sw_b", {31'b0, ram_switch}, 1);
        wait_drain("b2b_drain");
        check("b2b_sw_end", {31'b0, ram_switch}, 0);

        do_reset();
        or_mode = 1;
        send_block(100, N, st);
        wait_drain("toggle_drain");
        or_mode = 0;

        do_reset();
        or_mode = 2;
        send_block(0, N, st);
        or_mode = 0;
        fork
            send_block(2000, N, st);
            begin
                repeat (100) @(posedge CLK);
                #1;
                or_mode = 2;
            end
        join
        check("slow_sw_pre", {31'b0, ram_switch}, 1);
        or_mode = 0;
        p1 = -1;
        p2 = -1;
        t = 0;
        while (t < 3000) begin
            @(negedge CLK);
            if (in_ready) break;
            p2 = p1;
            p1 = int'(ram_readAddr);
            t++;
        end
        check("slow_stalled", {31'b0, t > 800}, 1);
        check("slow_ra_last", p2, N - 1);
        check("slow_ra_wrap", p1, 0);
        check("slow_sw_post", {31'b0, ram_switch}, 0);
        @(posedge CLK);
        #1;
        wait_drain("slow_drain");

        do_reset();
        or_mode = 2;
        send_block(0, N, st);
        send_block(3000, 512, st);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("mr_pre_valid", {31'b0, out_valid}, 1);
        check("mr_pre_waddr", {22'b0, ram_writeAddr}, 512);
        check("mr_pre_sw", {31'b0, ram_switch}, 1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("mr_valid", {31'b0, out_valid}, 0);
        check("mr_sw", {31'b0, ram_switch}, 0);
        check("mr_waddr", {22'b0, ram_writeAddr}, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        or_mode = 0;
        send_block(7000, N, st);
        wait_drain("mr_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pingpong_buf_ctrl.md
# pingpong_buf_ctrl

Controller driving the 18-bit ping-pong RAM from both sides. Accepts a valid/ready sample stream and fills the write bank at incrementing addresses. Swaps banks through `switch` when a bank is full and the reader is idle. Drains the other bank as a valid/ready output stream with `last` marking, and absorbs the RAM's 1-cycle read latency with a 2-entry skid buffer.

## Interface
- `addr_size`, default 10: RAM address width; block length N = 2**addr_size samples.
- `CLK` in 1: sole clock, all logic on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: controller can accept a sample.
- `in_data` in 18: input sample.
- `out_valid` out 1: output sample valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out 18: output sample.
- `out_last` out 1: qualifies the sample read from address N-1.
- `ram_WE` out 1: RAM write enable.
- `ram_switch` out 1: bank select; 0 writes RAM0 and reads RAM1, 1 the reverse.
- `ram_writeAddr` out addr_size: RAM write address.
- `ram_writeData` out 18: RAM write data.
- `ram_readAddr` out addr_size: RAM read address.
- `ram_readData` in 18: registered RAM read data, valid 1 cycle after address sampled.

## Operation
- **Write FSM:**
  - W_FILL: `in_ready`=1. Accept when `in_valid`&`in_ready`. Accept drives `ram_WE`=1, `ram_writeAddr`=wcnt, `ram_writeData`=`in_data` (combinational), and wcnt+1 at the edge. Accepting at wcnt=N-1 wraps wcnt to 0 and moves to W_WAIT.
  - W_WAIT: `in_ready`=0, `ram_WE`=0.
- **Swap:** on an edge where write FSM is W_WAIT and read FSM is R_IDLE:
  - toggle `ram_switch`;
  - write FSM moves to W_FILL;
  - read FSM moves to R_DRAIN with rcnt=0.
  - Never swap while R_DRAIN.
- **Read FSM:**
  - R_IDLE: no reads issued.
  - R_DRAIN: `ram_readAddr`=rcnt. A read is issued on an edge when credit exists: skid_count + inflight − pop ≤ 1, where pop = `out_valid`&`out_ready`.
  - An issue sets the inflight flag and increments rcnt. Issuing at rcnt=N-1 returns rcnt to 0 and the FSM to R_IDLE.
  - `ram_readAddr` holds rcnt when not issuing.
- **Skid:**
  - On the edge after an issue (inflight=1), `ram_readData` is pushed, tagged last if its address was N-1.
  - Push and pop may coincide. FIFO order.
  - `out_valid` = skid non-empty; `out_data`/`out_last` = head entry.
- Skid and inflight survive a swap. Data already captured or in flight belongs to the old bank.
- **Reset values:**
  - `in_ready`=0 while `RST` high, 1 in the first cycle after.
  - `out_valid`=0, `out_last`=0, `out_data`=0.
  - `ram_switch`=0, `ram_WE`=0.
  - `ram_writeAddr`=0, `ram_readAddr`=0.
  - wcnt=rcnt=0, skid empty, inflight=0.
  - States W_FILL and R_IDLE.
- Reset mid-operation discards all buffered data and both partial blocks, and returns `switch` to 0. RAM contents are not cleared.

## Timing
- Input throughput: 1 sample/cycle within a block. There is at least one `in_ready`=0 cycle (W_WAIT) per block, at the swap edge.
- Last input accepted at edge k, with reader idle:
  - k+1: swap;
  - k+2: first read issued;
  - k+3: skid push;
  - `out_valid`=1 from the cycle after k+3.
- Sustained output: 1 sample/cycle while `out_ready`=1.
- Backpressure: `out_valid` and `out_data` hold stable until accepted. Skid never overflows.
- A writer filling faster than the reader drains waits in W_WAIT. The swap occurs on the edge after the reader's last issue.
- Simultaneous full bank and reader completion at one edge: swap on the following edge.

## Structure
- Shared package:
  - `DATA_W`=18;
  - write-FSM state encodings W_FILL/W_WAIT;
  - read-FSM state encodings R_IDLE/R_DRAIN.
- One sub-module, `out_skid_buf`: 2-entry, 19-bit (data+last) FIFO with push/pop, count, head outputs.
- The RAM itself is instantiated by the parent, not inside this block.

## Test plan
- Reset, then stream N=1024 samples 0..1023 with continuous `in_valid`, `out_ready`=1:
  - `out_data` sequence 0..1023;
  - `out_last` only on 1023;
  - first `out_valid` 3 edges after the last accept.
- Two back-to-back blocks (0..1023, then 5000..6023):
  - `ram_switch` toggles 0→1→0;
  - `in_ready` low exactly 1 cycle between blocks when the reader is idle;
  - output order preserved.
- `out_ready` toggling 1/0 each cycle during drain: no sample lost or duplicated, `out_data` stable while `out_valid`&!`out_ready`.
- Writer finishes block 2 while reader has drained only 100 samples of block 1:
  - `in_ready`=0 until the reader issues address 1023;
  - swap on the next edge.
- Assert `RST` mid-block (wcnt=512, skid holding 2):
  - next cycle `out_valid`=0, `ram_switch`=0, `ram_writeAddr`=0;
  - a fresh 1024-sample block then drains correctly.
